// File: rtl/sort_job_arbiter_if.sv
// Bundle between the requester ports, the shared sort array and the consumer
// on one side and sort_job_arbiter on the other.
//
// Handshake: an element moves on a rising clk edge where the producer's
// valid and the consumer's ready are both high. Load has no ready (the
// arbiter takes every in_valid of the owner while loading). On the output
// side out_valid, once high, stays high with out_id/out_last unchanged until
// out_ready completes the beat.
interface sort_job_arbiter_if #(
  parameter int N_REQ = 4,
  parameter int W     = 16,
  parameter int IDW   = $clog2(N_REQ)
);
  logic [N_REQ-1:0]   req;
  logic [N_REQ-1:0]   in_valid;
  logic [N_REQ*W-1:0] in_data;
  logic [N_REQ-1:0]   gnt;
  logic               busy;
  logic               arr_load_en;
  logic [W-1:0]       arr_load_data;
  logic               even_cmp_en;
  logic               odd_cmp_en;
  logic               swap_seen;
  logic               out_valid;
  logic               out_ready;
  logic               arr_shift_out_en;
  logic [IDW-1:0]     out_id;
  logic               out_last;
  logic               job_done;
  logic [1:0]         state_dbg;

  modport master (
    input  req, in_valid, in_data, swap_seen, out_ready,
    output gnt, busy, arr_load_en, arr_load_data, even_cmp_en, odd_cmp_en,
           out_valid, arr_shift_out_en, out_id, out_last, job_done, state_dbg
  );

  modport slave (
    output req, in_valid, in_data, swap_seen, out_ready,
    input  gnt, busy, arr_load_en, arr_load_data, even_cmp_en, odd_cmp_en,
           out_valid, arr_shift_out_en, out_id, out_last, job_done, state_dbg
  );
endinterface

// File: rtl/sort_job_arbiter.sv
// Round-robin arbiter and job sequencer for a shared odd-even transposition
// sort array: IDLE picks a requester, LOAD streams its elements into the
// array, SORT strobes the compare-exchange phases, UNLOAD pops the result.
// Optional macro SORT_EARLY_EXIT_EN: leave SORT once an even/odd phase pair
// produced no swap.
module sort_job_arbiter #(
  parameter int N_REQ  = 4,
  parameter int N_ELEM = 8,
  parameter int W      = 16
) (
  input logic                clk,
  input logic                rst,
  sort_job_arbiter_if.master bus
);
  localparam int IDW = $clog2(N_REQ);
  localparam int CW  = $clog2(N_ELEM + 1);
  localparam logic [CW-1:0] LAST = CW'(N_ELEM - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, LOAD = 2'd1, SORT = 2'd2, UNLOAD = 2'd3} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [N_REQ-1:0] gnt_q, gnt_d;
  logic [IDW-1:0]   id_q, id_d;
  logic [IDW-1:0]   rr_q, rr_d;
  logic [IDW-1:0]   pick;
  logic [IDW-1:0]   scan;
  logic             pick_ok;
  logic             load_acc;
  logic             out_hs;
  logic             last_beat;
  logic             sort_exit_early;

  // First requesting index at or after rr_q, wrapping past N_REQ-1.
  always_comb begin
    pick    = '0;
    scan    = '0;
    pick_ok = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      scan = IDW'((int'(rr_q) + i) % N_REQ);
      if (!pick_ok && bus.req[scan]) begin
        pick    = scan;
        pick_ok = 1'b1;
      end
    end
  end

  assign load_acc  = (state_q == LOAD) && bus.in_valid[id_q];
  assign out_hs    = (state_q == UNLOAD) && bus.out_ready;
  assign last_beat = (cnt_q == LAST);

`ifdef SORT_EARLY_EXIT_EN
  logic even_swap_q;

  // Remember whether the even phase of the current pair swapped anything.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      even_swap_q <= 1'b0;
    else if (state_q == SORT && !cnt_q[0])
      even_swap_q <= bus.swap_seen;
  end

  // A clean even phase followed by a clean odd phase means the data is sorted.
  assign sort_exit_early = (state_q == SORT) && cnt_q[0] && !bus.swap_seen && !even_swap_q;
`else
  assign sort_exit_early = 1'b0;
`endif

  // Next-state, counter, grant and round-robin pointer update.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    gnt_d   = gnt_q;
    id_d    = id_q;
    rr_d    = rr_q;
    case (state_q)
      IDLE: begin
        if (pick_ok) begin
          state_d = LOAD;
          id_d    = pick;
          gnt_d   = N_REQ'(1) << pick;
        end
      end
      LOAD: begin
        if (load_acc) begin
          if (last_beat) state_d = SORT;
          else           cnt_d   = cnt_q + 1'b1;
        end
      end
      SORT: begin
        if (last_beat || sort_exit_early) state_d = UNLOAD;
        else                              cnt_d   = cnt_q + 1'b1;
      end
      UNLOAD: begin
        if (out_hs) begin
          if (last_beat) begin
            state_d = IDLE;
            gnt_d   = '0;
            rr_d    = (int'(id_q) == N_REQ - 1) ? '0 : id_q + 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    // Every state starts counting from zero.
    if (state_d != state_q) cnt_d = '0;
  end

  // State register; reset aborts any job without a job_done.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      gnt_q   <= '0;
      id_q    <= '0;
      rr_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      gnt_q   <= gnt_d;
      id_q    <= id_d;
      rr_q    <= rr_d;
    end
  end

  assign bus.gnt              = gnt_q;
  assign bus.busy             = (state_q != IDLE);
  assign bus.arr_load_en      = load_acc;
  assign bus.arr_load_data    = (state_q == LOAD) ? bus.in_data[int'(id_q)*W +: W] : '0;
  assign bus.even_cmp_en      = (state_q == SORT) && !cnt_q[0];
  assign bus.odd_cmp_en       = (state_q == SORT) && cnt_q[0];
  assign bus.out_valid        = (state_q == UNLOAD);
  assign bus.arr_shift_out_en = out_hs;
  assign bus.out_id           = id_q;
  assign bus.out_last         = (state_q == UNLOAD) && last_beat;
  assign bus.job_done         = out_hs && last_beat;
  assign bus.state_dbg        = state_q;
endmodule

// File: tb/tb_sort_job_arbiter.sv
// Directed bench for sort_job_arbiter: first grant, mid-job reset,
// round-robin order with stalls and a swap-free sort, late requester.
module tb_sort_job_arbiter;
  localparam int N_REQ  = 4;
  localparam int N_ELEM = 8;
  localparam int W      = 16;
`ifdef SORT_EARLY_EXIT_EN
  localparam int FAST_SORT = 2;
`else
  localparam int FAST_SORT = 8;
`endif

  logic clk;
  logic rst;
  int   n_vec = 0;
  int   n_bad = 0;

  sort_job_arbiter_if #(.N_REQ(N_REQ), .W(W)) bus ();

  sort_job_arbiter #(.N_REQ(N_REQ), .N_ELEM(N_ELEM), .W(W)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // safety net in case a loop bound is ever bypassed
  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected summary");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // advance one cycle; observation point is 2 time units after the edge
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Called at the first LOAD observation point of a job owned by id.
  task automatic run_job(input int id, input bit load_stall, input bit out_stall,
                         input bit no_swap, input int exp_sort, input int rst_ph,
                         input bit late_req);
    int n_cyc, n_en, k, beats, stall_left, bad_seq, bad_id;
    logic [N_REQ-1:0] own;
    own = N_REQ'(1) << id;
    check("gnt", bus.gnt, own);
    check("busy", bus.busy, 1);
    check("out_id", bus.out_id, id);
    check("load_data", bus.arr_load_data, 32'hA000 + id);

    n_cyc = 0;
    n_en  = 0;
    while (bus.busy && !bus.even_cmp_en && !bus.odd_cmp_en && !bus.out_valid && n_cyc < 64) begin
      if (load_stall) begin
        bus.in_valid = (n_cyc % 2 == 0) ? '0 : '1;
        #1;
      end
      if (bus.arr_load_en) n_en++;
      n_cyc++;
      tick();
    end
    bus.in_valid = '1;
    check("load_cycles", n_cyc, load_stall ? 16 : 8);
    check("load_beats", n_en, 8);

    bus.swap_seen = !no_swap;
    k = 0;
    bad_seq = 0;
    while (bus.busy && (bus.even_cmp_en || bus.odd_cmp_en) && k < 64) begin
      if (bus.even_cmp_en !== (k % 2 == 0) || bus.odd_cmp_en !== (k % 2 == 1)) bad_seq++;
      if (k == rst_ph) begin
        rst = 1'b1;
        #1;
        check("rst_gnt", bus.gnt, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_even", bus.even_cmp_en, 0);
        check("rst_odd", bus.odd_cmp_en, 0);
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_out_id", bus.out_id, 0);
        check("rst_load_en", bus.arr_load_en, 0);
        check("rst_load_data", bus.arr_load_data, 0);
        check("rst_shift", bus.arr_shift_out_en, 0);
        check("rst_last", bus.out_last, 0);
        check("rst_done", bus.job_done, 0);
        #1;
        rst = 1'b0;
        bus.swap_seen = 1'b1;
        return;
      end
      k++;
      tick();
    end
    bus.swap_seen = 1'b1;
    check("sort_cycles", k, exp_sort);
    check("sort_alternation", bad_seq, 0);
    check("unload_valid", bus.out_valid, 1);

    if (late_req) bus.req = 4'b0100;
    beats      = 0;
    stall_left = out_stall ? 3 : 0;
    bad_id     = 0;
    n_cyc      = 0;
    while (bus.out_valid && n_cyc < 64) begin
      n_cyc++;
      if (beats == 3 && stall_left > 0) begin
        bus.out_ready = 1'b0;
        #1;
        check("stall_valid", bus.out_valid, 1);
        check("stall_shift", bus.arr_shift_out_en, 0);
        check("stall_done", bus.job_done, 0);
        if (int'(bus.out_id) != id || bus.out_last !== 1'b0) bad_id++;
        stall_left--;
        tick();
        continue;
      end
      bus.out_ready = 1'b1;
      #1;
      if (int'(bus.out_id) != id || bus.gnt !== own) bad_id++;
      check("beat_shift", bus.arr_shift_out_en, 1);
      check("beat_last", bus.out_last, (beats == 7) ? 1 : 0);
      check("beat_done", bus.job_done, (beats == 7) ? 1 : 0);
      beats++;
      tick();
    end
    check("beats", beats, 8);
    check("owner_stable", bad_id, 0);
    check("gap_gnt", bus.gnt, 0);
    check("gap_busy", bus.busy, 0);
  endtask

  initial begin
    rst           = 1'b1;
    bus.req       = '0;
    bus.in_valid  = '0;
    bus.in_data   = '0;
    bus.swap_seen = 1'b1;
    bus.out_ready = 1'b1;
    for (int i = 0; i < N_REQ; i++) bus.in_data[i*W +: W] = W'(16'hA000 + i);
    #1;
    check("reset_gnt", bus.gnt, 0);
    check("reset_busy", bus.busy, 0);
    check("reset_out_valid", bus.out_valid, 0);
    check("reset_load_en", bus.arr_load_en, 0);
    check("reset_cmp", {bus.even_cmp_en, bus.odd_cmp_en}, 0);
    check("reset_done", bus.job_done, 0);
    repeat (2) tick();
    rst = 1'b0;
    tick();

    // first grant to requester 1; req dropped right after the grant
    bus.in_valid = '1;
    bus.req      = 4'b0010;
    check("idle_gnt", bus.gnt, 0);
    tick();
    bus.req = '0;
    run_job(1, 1'b0, 1'b0, 1'b0, 8, -1, 1'b0);
    tick();
    check("no_regrant", bus.gnt, 0);

    // requester 2 (pointer now 2), reset at SORT phase 3
    bus.req = 4'b0100;
    tick();
    bus.req = '0;
    run_job(2, 1'b0, 1'b0, 1'b0, 8, 3, 1'b0);
    tick();
    check("post_rst_idle", bus.busy, 0);

    // all requesting: pointer back at 0 gives 0,1,2,3,0
    bus.req = '1;
    for (int j = 0; j < 5; j++) begin
      if (j == 4) begin
        tick();
        bus.req = '0;
        run_job(0, 1'b0, 1'b0, 1'b0, 8, -1, 1'b0);
      end else begin
        tick();
        run_job(j, (j == 2), (j == 2), (j == 3), (j == 3) ? FAST_SORT : 8, -1, 1'b0);
      end
    end
    tick();
    check("rr_quiet", bus.gnt, 0);

    // late requester rises during requester 0's UNLOAD
    bus.req = 4'b0001;
    tick();
    run_job(0, 1'b0, 1'b0, 1'b0, 8, -1, 1'b1);
    tick();
    check("late_gnt", bus.gnt, 4'b0100);
    check("late_id", bus.out_id, 2);
    bus.req = '0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/sort_job_arbiter.md
# sort_job_arbiter

Round-robin arbiter and job sequencer that shares one odd-even transposition sort array among `N_REQ` requesters. A job has three phases: load `N_ELEM` elements from the granted requester, run the compare-exchange phases, then stream the sorted result out with backpressure. The block sits between the requester ports and the sort array and owns every array control strobe; the array itself holds all element storage.

## Interface
- `N_REQ`, 4: number of requesters (2..8).
- `N_ELEM`, 8: elements per job, even, at least 2.
- `W`, 16: element width in bits.
- `IDW`, `$clog2(N_REQ)`: width of the requester id.

Ports:
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst`  in  1  reset, asynchronous and active-high.
- `req`  in  `N_REQ`  per-requester job request, level.
- `in_valid`  in  `N_REQ`  per-requester element valid during load.
- `in_data`  in  `N_REQ*W`  per-requester element; requester i uses bits `[i*W +: W]`.
- `gnt`  out  `N_REQ`  one-hot grant, held for the whole job.
- `busy`  out  1  a job is in progress (any state except IDLE).
- `arr_load_en`  out  1  shift `arr_load_data` into the array.
- `arr_load_data`  out  `W`  element muxed from the granted requester.
- `even_cmp_en`  out  1  compare-exchange pairs (0,1),(2,3),...
- `odd_cmp_en`  out  1  compare-exchange pairs (1,2),(3,4),...
- `swap_seen`  in  1  the array swapped at least one pair this cycle; combinational, valid while a cmp_en is high.
- `out_valid`  out  1  the array head holds a sorted element for the consumer.
- `out_ready`  in  1  consumer accepts the element.
- `arr_shift_out_en`  out  1  equals `out_valid & out_ready`; pops the array head.
- `out_id`  out  `IDW`  id of the job owner.
- `out_last`  out  1  the current output element is the final element of the job.
- `job_done`  out  1  one-cycle pulse, coincident with the last output handshake.

## Operation
- States: IDLE, LOAD, SORT, UNLOAD.
- **IDLE**
  - When any `req` bit is set, select the first set bit at or after `rr_ptr`, searching upward and wrapping.
  - Register the selection into `gnt` and `out_id` and move to LOAD.
- **LOAD**
  - `arr_load_en = in_valid[id]`; `arr_load_data = in_data[id]`.
  - Count accepted elements. The `N_ELEM`-th acceptance moves the state to SORT.
  - `in_valid` from non-granted requesters is ignored.
- **SORT**
  - Phase counter `ph` runs 0..`N_ELEM-1`, one phase per cycle.
  - `even_cmp_en` is high when `ph` is even; `odd_cmp_en` is high when `ph` is odd. The two are never high together.
  - After `ph = N_ELEM-1`, move to UNLOAD.
- **UNLOAD**
  - `out_valid` is high until `N_ELEM` handshakes complete.
  - `out_last` is high while the output count equals `N_ELEM-1`.
  - On the final handshake: pulse `job_done`, drop `gnt`, set `rr_ptr = id+1` (mod `N_REQ`), and return to IDLE.
- A requester dropping `req` mid-job has no effect; the job runs to completion. `req` is sampled only in IDLE.
- Counters are `$clog2(N_ELEM+1)` bits wide and are cleared on every state entry.

## Timing
- Reset values: every output is 0, `rr_ptr` is 0, all counters are 0, the state is IDLE.
- Reset asserted mid-job aborts immediately to the reset values. No `job_done` is produced for the aborted job.
- Grant latency: `req` high in cycle t (state IDLE) gives `gnt` and `busy` high at t+1.
- LOAD length: `N_ELEM` cycles when `in_valid` is held high; stall cycles extend it one-for-one.
- SORT length: exactly `N_ELEM` cycles; with SORT_EARLY_EXIT_EN it can be shorter, see Configuration.
- UNLOAD: `out_valid` rises in the cycle after the last SORT cycle.
  - `out_valid` holds through `out_ready` stalls.
  - `out_id` and `out_last` are stable while stalled.
- IDLE occupies at least one cycle between jobs. Back-to-back jobs therefore have a one-cycle gap from `job_done` to the next `gnt`.
- `req` from the owner of the previous job in the cycle after `job_done` has the lowest priority, because `rr_ptr` has moved past it.

## Configuration
- Macro `SORT_EARLY_EXIT_EN`.
- **Defined:** SORT tracks `swap_seen` across each even/odd phase pair.
  - Condition: an odd phase completes and `swap_seen` was low in both that phase and the even phase before it.
  - Action: leave SORT in the next cycle, exactly as if the last phase had completed.
  - Minimum SORT length is 2 cycles.
- **Undefined:** `swap_seen` is ignored and SORT always runs `N_ELEM` phases.

## Test plan
- **Reset and first grant:** `req=4'b0010` with `in_valid` held high and `out_ready` high.
  - `gnt=0010` one cycle later.
  - 8 cycles with `arr_load_en` high.
  - 8 SORT cycles alternating even/odd starting with even.
  - 8 `out_valid` beats with `out_id=1`; `out_last` and `job_done` both on beat 8.
- **Round-robin fairness:** `req=4'b1111` held throughout.
  - Grants in order 0,1,2,3,0.
  - Exactly one IDLE cycle between each `job_done` and the next `gnt`.
- **Stalls:** LOAD with `in_valid` low on alternate cycles gives a 16-cycle LOAD. UNLOAD with `out_ready` low for 3 cycles on beat 4 holds `out_valid` high and `arr_shift_out_en` low for those cycles.
- **Reset mid-job:** `rst` pulsed high at SORT `ph=3`.
  - All outputs read 0 asynchronously.
  - The next `req=0001` is granted to requester 0, since `rr_ptr` is back at 0.
- **Early exit (`SORT_EARLY_EXIT_EN` defined):** `swap_seen` held at 0 gives SORT = 2 cycles, then UNLOAD. With the macro undefined, the same stimulus gives SORT = 8 cycles.
- **Late requester:** `req=0100` rises while requester 0's job is in UNLOAD. There is no grant change mid-job; `gnt=0100` is asserted 2 cycles after `job_done`.
